// File: rtl/wishbone_to_axi4l_bridge.sv
// rtl/wishbone_to_axi4l_bridge.sv - Wishbone classic slave to AXI4-Lite master bridge, one access in flight.
// Optional response-error reporting: define WISHBONE_TO_AXI4L_RESP_ERR_EN.
module wishbone_to_axi4l_bridge #(
  parameter int WB_DAT_SIZE      = 3,
  parameter int WB_ADR_WIDTH     = 37,
  parameter int WB_DAT_WIDTH     = 8 << WB_DAT_SIZE,
  parameter int WB_SEL_WIDTH     = 1 << WB_DAT_SIZE,
  parameter int AXI4L_ADDR_WIDTH = 40
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [WB_ADR_WIDTH-1:0]     s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]     s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]     s_wb_dat_o,
  input  logic                        s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]     s_wb_sel_i,
  input  logic                        s_wb_stb_i,
  output logic                        s_wb_ack_o,
  output logic                        s_wb_err_o,
  output logic [AXI4L_ADDR_WIDTH-1:0] m_axi4l_awaddr_o,
  output logic [2:0]                  m_axi4l_awprot_o,
  output logic                        m_axi4l_awvalid_o,
  input  logic                        m_axi4l_awready_i,
  output logic [WB_DAT_WIDTH-1:0]     m_axi4l_wdata_o,
  output logic [WB_SEL_WIDTH-1:0]     m_axi4l_wstrb_o,
  output logic                        m_axi4l_wvalid_o,
  input  logic                        m_axi4l_wready_i,
  input  logic [1:0]                  m_axi4l_bresp_i,
  input  logic                        m_axi4l_bvalid_i,
  output logic                        m_axi4l_bready_o,
  output logic [AXI4L_ADDR_WIDTH-1:0] m_axi4l_araddr_o,
  output logic [2:0]                  m_axi4l_arprot_o,
  output logic                        m_axi4l_arvalid_o,
  input  logic                        m_axi4l_arready_i,
  input  logic [WB_DAT_WIDTH-1:0]     m_axi4l_rdata_i,
  input  logic [1:0]                  m_axi4l_rresp_i,
  input  logic                        m_axi4l_rvalid_i,
  output logic                        m_axi4l_rready_o
);

`ifdef WISHBONE_TO_AXI4L_RESP_ERR_EN
  localparam bit RESP_ERR_EN = 1'b1;
`else
  localparam bit RESP_ERR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ACK} state_t;

  state_t                      state_q, state_d;
  logic [AXI4L_ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [WB_DAT_WIDTH-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic [WB_SEL_WIDTH-1:0]     wstrb_q, wstrb_d;
  logic                        awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                        arvalid_q, arvalid_d;
  logic                        resp_err_q, resp_err_d;
  logic [AXI4L_ADDR_WIDTH-1:0] req_addr;

  // Word address to byte address; the cast zero-extends or truncates to the AXI width.
  assign req_addr = AXI4L_ADDR_WIDTH'({s_wb_adr_i, {WB_DAT_SIZE{1'b0}}});

  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    resp_err_d = resp_err_q;
    case (state_q)
      IDLE: begin
        if (s_wb_stb_i) begin
          resp_err_d = 1'b0;
          if (s_wb_we_i) begin
            awaddr_d  = req_addr;
            wdata_d   = s_wb_dat_i;
            wstrb_d   = s_wb_sel_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = req_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (m_axi4l_awready_i) awvalid_d = 1'b0;
        if (m_axi4l_wready_i)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi4l_bvalid_i) begin
          resp_err_d = RESP_ERR_EN && (m_axi4l_bresp_i != 2'b00);
          state_d    = ACK;
        end
      end
      RD_REQ: begin
        if (m_axi4l_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi4l_rvalid_i) begin
          resp_err_d = RESP_ERR_EN && (m_axi4l_rresp_i != 2'b00);
          rdata_d    = resp_err_d ? '0 : m_axi4l_rdata_i;
          state_d    = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign s_wb_dat_o        = rdata_q;
  assign s_wb_ack_o        = (state_q == ACK);
  assign s_wb_err_o        = (state_q == ACK) && resp_err_q;
  assign m_axi4l_awaddr_o  = awaddr_q;
  assign m_axi4l_awprot_o  = 3'b000;
  assign m_axi4l_awvalid_o = awvalid_q;
  assign m_axi4l_wdata_o   = wdata_q;
  assign m_axi4l_wstrb_o   = wstrb_q;
  assign m_axi4l_wvalid_o  = wvalid_q;
  assign m_axi4l_bready_o  = (state_q == WR_RESP);
  assign m_axi4l_araddr_o  = araddr_q;
  assign m_axi4l_arprot_o  = 3'b000;
  assign m_axi4l_arvalid_o = arvalid_q;
  assign m_axi4l_rready_o  = (state_q == RD_RESP);

endmodule

// File: tb/tb_wishbone_to_axi4l_bridge.sv
// tb/tb_wishbone_to_axi4l_bridge.sv - randomized bench with a per-cycle transaction timeline model.
module tb_wishbone_to_axi4l_bridge;
  localparam int AW = 37, DW = 64, SW = 8, XW = 40;
`ifdef WISHBONE_TO_AXI4L_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat, wb_dat_o;
  logic          wb_we, wb_stb, wb_ack, wb_err;
  logic [SW-1:0] wb_sel;
  logic [XW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  wishbone_to_axi4l_bridge dut (
    .clk(clk), .resetn(resetn),
    .s_wb_adr_i(wb_adr), .s_wb_dat_i(wb_dat), .s_wb_dat_o(wb_dat_o), .s_wb_we_i(wb_we),
    .s_wb_sel_i(wb_sel), .s_wb_stb_i(wb_stb), .s_wb_ack_o(wb_ack), .s_wb_err_o(wb_err),
    .m_axi4l_awaddr_o(awaddr), .m_axi4l_awprot_o(awprot), .m_axi4l_awvalid_o(awvalid),
    .m_axi4l_awready_i(awready), .m_axi4l_wdata_o(wdata), .m_axi4l_wstrb_o(wstrb),
    .m_axi4l_wvalid_o(wvalid), .m_axi4l_wready_i(wready), .m_axi4l_bresp_i(bresp),
    .m_axi4l_bvalid_i(bvalid), .m_axi4l_bready_o(bready), .m_axi4l_araddr_o(araddr),
    .m_axi4l_arprot_o(arprot), .m_axi4l_arvalid_o(arvalid), .m_axi4l_arready_i(arready),
    .m_axi4l_rdata_i(rdata), .m_axi4l_rresp_i(rresp), .m_axi4l_rvalid_i(rvalid),
    .m_axi4l_rready_o(rready)
  );

  // Expected outputs for the current cycle, written only by the stimulus process.
  logic          e_awv, e_wv, e_arv, e_br, e_rr, e_ack, e_err;
  logic [DW-1:0] e_dat, e_wdata, last_rd;
  logic [XW-1:0] e_awaddr, e_araddr;
  logic [SW-1:0] e_wstrb;
  bit            chk_en, zero_chk;
  int            cur_k;
  bit            pin_en, pin_rd, pin_err;
  int            pin_ack;
  logic [XW-1:0] pin_addr;
  logic [DW-1:0] pin_wdata, pin_dat;
  int            tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("awvalid", 64'(awvalid), 64'(e_awv));
      chk("wvalid", 64'(wvalid), 64'(e_wv));
      chk("arvalid", 64'(arvalid), 64'(e_arv));
      chk("bready", 64'(bready), 64'(e_br));
      chk("rready", 64'(rready), 64'(e_rr));
      chk("ack", 64'(wb_ack), 64'(e_ack));
      chk("err", 64'(wb_err), 64'(e_err));
      chk("dat_o", wb_dat_o, e_dat);
      chk("prot", 64'({awprot, arprot}), 64'(0));
      if (e_awv) chk("awaddr", 64'(awaddr), 64'(e_awaddr));
      if (e_wv) begin
        chk("wdata", wdata, e_wdata);
        chk("wstrb", 64'(wstrb), 64'(e_wstrb));
      end
      if (e_arv) chk("araddr", 64'(araddr), 64'(e_araddr));
      if (zero_chk) begin
        chk("rst_awaddr", 64'(awaddr), 64'(0));
        chk("rst_araddr", 64'(araddr), 64'(0));
        chk("rst_wdata", wdata, 64'(0));
        chk("rst_wstrb", 64'(wstrb), 64'(0));
      end
      if (pin_en && awvalid) chk("pin_awaddr", 64'(awaddr), 64'(pin_addr));
      if (pin_en && wvalid) chk("pin_wdata", wdata, pin_wdata);
      if (pin_en && arvalid) chk("pin_araddr", 64'(araddr), 64'(pin_addr));
      if (pin_en && wb_ack) begin
        chk("pin_ack_cycle", 64'(cur_k), 64'(pin_ack));
        chk("pin_err", 64'(wb_err), 64'(pin_err));
        if (pin_rd) chk("pin_dat_o", wb_dat_o, pin_dat);
      end
    end
  end

  task automatic noise();
    wb_adr = AW'({$urandom(), $urandom()});
    wb_dat = {$urandom(), $urandom()};
    wb_sel = SW'($urandom());
    wb_we  = 1'($urandom());
  endtask

  task automatic idle_exp();
    {e_awv, e_wv, e_arv, e_br, e_rr, e_ack, e_err} = '0;
    e_dat = last_rd;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cur_k = -1; zero_chk = 0;
      wb_stb = 0; noise();
      awready = 1'($urandom()); wready = 1'($urandom()); arready = 1'($urandom());
      bvalid = 0; rvalid = 0;
      idle_exp();
    end
  endtask

  // d1: aw (write) or ar (read) ready delay, d2: w ready delay, d3: b/r valid delay.
  task automatic txn(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                     input logic [SW-1:0] sel, input int d1, input int d2, input int d3,
                     input logic [1:0] resp, input logic [DW-1:0] rdat, input int rst_at);
    int m, len;
    logic [DW-1:0] new_rd;
    m      = (we && d2 > d1) ? d2 : d1;
    len    = 3 + m + d3;
    new_rd = (ERR_EN && resp != 2'b00) ? '0 : rdat;
    for (int k = 0; k <= len; k++) begin
      @(posedge clk); #1;
      cur_k = k; zero_chk = 0;
      wb_stb = 1;
      if (k == 0) begin
        wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we;
      end else noise();
      awready = 1'($urandom()); wready = 1'($urandom()); arready = 1'($urandom());
      if (we) begin
        awready = (k < 1 + d1) ? 1'b0 : (k == 1 + d1) ? 1'b1 : awready;
        wready  = (k < 1 + d2) ? 1'b0 : (k == 1 + d2) ? 1'b1 : wready;
      end else
        arready = (k < 1 + d1) ? 1'b0 : (k == 1 + d1) ? 1'b1 : arready;
      bvalid = we && (k == 2 + m + d3);
      rvalid = !we && (k == 2 + m + d3);
      bresp  = bvalid ? resp : 2'($urandom());
      rresp  = rvalid ? resp : 2'($urandom());
      rdata  = rvalid ? rdat : {$urandom(), $urandom()};
      e_awv  = we && k >= 1 && k <= 1 + d1;
      e_wv   = we && k >= 1 && k <= 1 + d2;
      e_arv  = !we && k >= 1 && k <= 1 + d1;
      e_br   = we && k >= 2 + m && k <= 2 + m + d3;
      e_rr   = !we && k >= 2 + m && k <= 2 + m + d3;
      e_ack  = (k == len);
      e_err  = (k == len) && ERR_EN && resp != 2'b00;
      e_dat  = (!we && k == len) ? new_rd : last_rd;
      e_awaddr = XW'({adr, 3'b000});
      e_araddr = XW'({adr, 3'b000});
      e_wdata  = dat;
      e_wstrb  = sel;
      if (k == rst_at) begin
        resetn = 0;
        @(posedge clk); #1;
        resetn = 1; cur_k = -1; wb_stb = 0;
        bvalid = 0; rvalid = 0;
        last_rd = '0; idle_exp(); zero_chk = 1;
        return;
      end
    end
    if (!we) last_rd = new_rd;
  endtask

  initial begin
    chk_en = 0; zero_chk = 0; pin_en = 0; pin_rd = 0; pin_err = 0; pin_ack = 0;
    pin_addr = '0; pin_wdata = '0; pin_dat = '0; cur_k = -1; last_rd = '0;
    resetn = 0; wb_stb = 0; noise();
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = '0;
    idle_exp();
    repeat (2) @(posedge clk);
    #1; chk_en = 1; zero_chk = 1;
    @(posedge clk); #1; resetn = 1;
    idle(2);

    pin_en = 1; pin_rd = 0; pin_err = 0; pin_ack = 3;
    pin_addr = 40'h80; pin_wdata = 64'h1122_3344_5566_7788;
    txn(1, 37'h10, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 0, 2'b00, '0, -1);
    idle(1); pin_en = 0;

    pin_en = 1; pin_rd = 1; pin_ack = 8; pin_addr = 40'h100; pin_dat = 64'hDEAD_BEEF_0000_0001;
    txn(0, 37'h20, '0, '0, 0, 0, 5, 2'b00, 64'hDEAD_BEEF_0000_0001, -1);
    idle(3); pin_en = 0;

    txn(1, 37'h1234, 64'hA5A5_0000_FFFF_1111, 8'h0F, 0, 2, 1, 2'b00, '0, -1);
    txn(1, 37'h40, 64'h0102_0304_0506_0708, 8'hC3, 1, 0, 0, 2'b00, '0, -1);
    txn(0, 37'h41, '0, '0, 1, 0, 1, 2'b00, 64'hCAFE_F00D_1234_5678, -1);
    txn(1, 37'h42, 64'h99, 8'h01, 0, 0, 2, 2'b00, '0, -1);
    idle(1);

    pin_en = 1; pin_rd = 1; pin_ack = 3; pin_addr = 40'h180;
    pin_err = ERR_EN; pin_dat = ERR_EN ? 64'h0 : 64'h55;
    txn(0, 37'h30, '0, '0, 0, 0, 0, 2'b10, 64'h55, -1);
    idle(1); pin_en = 0;

    txn(0, 37'h50, '0, '0, 0, 0, 4, 2'b00, 64'h7777_8888_9999_AAAA, 3);
    idle(1);
    txn(1, 37'h51, 64'h1357_9BDF_2468_ACE0, 8'hAA, 0, 1, 1, 2'b00, '0, -1);

    for (int i = 0; i < 80; i++) begin
      logic [1:0] r;
      r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      txn(1'($urandom()), AW'({$urandom(), $urandom()}), {$urandom(), $urandom()},
          SW'($urandom()), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          r, {$urandom(), $urandom()}, -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);
    chk_en = 0;
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
